// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared state encoding and midpoint helper for sar_search
//
// Contents:
//   state_t   : controller states IDLE / SEARCH / DONE
//   midpoint  : (a + b) >> 1 evaluated with one extra carry bit so the sum never wraps
package sar_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned MID_MAX_WIDTH      = 32;

  // Operands are zero-extended into a 33-bit adder; for any width up to 32 this
  // equals a DATA_WIDTH+1-bit sum shifted right by one.
  function automatic logic [MID_MAX_WIDTH-1:0] midpoint(
    input logic [MID_MAX_WIDTH-1:0] a,
    input logic [MID_MAX_WIDTH-1:0] b
  );
    logic [MID_MAX_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MID_MAX_WIDTH:1];
  endfunction

endpackage

// File: rtl/sar_search.sv
// rtl/sar_search.sv - binary-search controller driving an external magnitude comparator
//
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   start, lo_bound, hi_bound : search request and inclusive bounds (sampled in IDLE)
//   probe, probe_valid        : registered probe to comparator input a, valid in SEARCH
//   cmp_equal/lower/greater   : comparator flags for probe vs key
//   busy                      : any state other than IDLE
//   done                      : one-cycle completion pulse
//   found, error, result      : outcome, held until the next accepted start
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] lo_bound,
  input  logic [DATA_WIDTH-1:0] hi_bound,
  output logic [DATA_WIDTH-1:0] probe,
  output logic                  probe_valid,
  input  logic                  cmp_equal,
  input  logic                  cmp_lower,
  input  logic                  cmp_greater,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] lo_q, lo_nxt;
  logic [DATA_WIDTH-1:0] hi_q, hi_nxt;
  logic [DATA_WIDTH-1:0] probe_q, probe_nxt;
  logic [DATA_WIDTH-1:0] result_q, result_nxt;
  logic                  found_q, found_nxt;
  logic                  error_q, error_nxt;

  logic [DATA_WIDTH-1:0] probe_inc;
  logic [DATA_WIDTH-1:0] probe_dec;
  logic [2:0]            flags;

  function automatic logic [DATA_WIDTH-1:0] mid(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [MID_MAX_WIDTH-1:0] m;
    m = midpoint(MID_MAX_WIDTH'(a), MID_MAX_WIDTH'(b));
    return m[DATA_WIDTH-1:0];
  endfunction

  // Only used on paths where probe < hi (inc) or probe > lo (dec), so neither wraps.
  assign probe_inc = probe_q + ONE;
  assign probe_dec = probe_q - ONE;
  assign flags     = {cmp_equal, cmp_lower, cmp_greater};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      lo_q     <= lo_nxt;
      hi_q     <= hi_nxt;
      probe_q  <= probe_nxt;
      result_q <= result_nxt;
      found_q  <= found_nxt;
      error_q  <= error_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    lo_nxt     = lo_q;
    hi_nxt     = hi_q;
    probe_nxt  = probe_q;
    result_nxt = result_q;
    found_nxt  = found_q;
    error_nxt  = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          found_nxt = 1'b0;
          error_nxt = 1'b0;
          if (lo_bound <= hi_bound) begin
            lo_nxt    = lo_bound;
            hi_nxt    = hi_bound;
            probe_nxt = mid(lo_bound, hi_bound);
            state_nxt = ST_SEARCH;
          end else begin
            // Empty range: report not-found without ever presenting a probe.
            result_nxt = lo_bound;
            state_nxt  = ST_DONE;
          end
        end
      end

      ST_SEARCH: begin
        case (flags)
          3'b100: begin
            found_nxt  = 1'b1;
            result_nxt = probe_q;
            state_nxt  = ST_DONE;
          end
          3'b010: begin
            if (probe_q == hi_q) begin
              result_nxt = probe_q;
              state_nxt  = ST_DONE;
            end else begin
              lo_nxt    = probe_inc;
              probe_nxt = mid(probe_inc, hi_q);
            end
          end
          3'b001: begin
            if (probe_q == lo_q) begin
              result_nxt = probe_q;
              state_nxt  = ST_DONE;
            end else begin
              hi_nxt    = probe_dec;
              probe_nxt = mid(lo_q, probe_dec);
            end
          end
          default: begin
            // Comparator flags are not one-hot: abandon the search.
            error_nxt  = 1'b1;
            result_nxt = probe_q;
            state_nxt  = ST_DONE;
          end
        endcase
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign probe       = probe_q;
  assign probe_valid = (state_q == ST_SEARCH);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign found       = found_q;
  assign error       = error_q;
  assign result      = result_q;

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - directed self-checking bench for sar_search
module tb_sar_search;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] lo_bound;
  logic [7:0] hi_bound;
  logic [7:0] probe;
  logic       probe_valid;
  logic       cmp_equal;
  logic       cmp_lower;
  logic       cmp_greater;
  logic       busy;
  logic       done;
  logic       found;
  logic       error;
  logic [7:0] result;

  logic [7:0] key;
  logic       force_bad;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] obs_probes [$];
  int         obs_done_cyc;
  logic       obs_found;
  logic       obs_error;
  logic [7:0] obs_result;
  logic       obs_done_after;
  logic [7:0] obs_result_after;

  sar_search #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .lo_bound    (lo_bound),
    .hi_bound    (hi_bound),
    .probe       (probe),
    .probe_valid (probe_valid),
    .cmp_equal   (cmp_equal),
    .cmp_lower   (cmp_lower),
    .cmp_greater (cmp_greater),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .error       (error),
    .result      (result)
  );

  // Comparator closing the loop: a = probe, b = key; force_bad raises two flags at once.
  assign cmp_equal   = !force_bad && (probe == key);
  assign cmp_lower   = force_bad || (probe < key);
  assign cmp_greater = force_bad || (probe > key);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts a search and records probes and the outcome; cycle 1 is the cycle after acceptance.
  task automatic run_search(input logic [7:0] l, input logic [7:0] h, input logic [7:0] k,
                            input logic bad);
    key = k;
    force_bad = bad;
    obs_probes.delete();
    obs_done_cyc = 0;
    obs_found = 1'bx;
    obs_error = 1'bx;
    obs_result = 'x;
    @(negedge clk);
    start = 1'b1;
    lo_bound = l;
    hi_bound = h;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (probe_valid) obs_probes.push_back(probe);
      if (done) begin
        obs_done_cyc = c;
        obs_found = found;
        obs_error = error;
        obs_result = result;
        break;
      end
    end
    @(negedge clk);
    obs_done_after = done;
    obs_result_after = result;
    force_bad = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    lo_bound = '0;
    hi_bound = '0;
    key = '0;
    force_bad = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({probe, probe_valid, busy, done, found, error, result} !== 21'd0)
      $display("FAIL reset_values got probe=%0d pv=%0b busy=%0b done=%0b found=%0b err=%0b result=%0d want all 0",
               probe, probe_valid, busy, done, found, error, result);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key_200();
    logic [7:0] exp_p [$];
    logic [7:0] a;
    exp_p = '{8'd127, 8'd191, 8'd223, 8'd207, 8'd199, 8'd203, 8'd201, 8'd200};
    run_search(8'd0, 8'd255, 8'd200, 1'b0);
    total_cnt++;
    if (obs_probes.size() != exp_p.size()) $display("FAIL k200_nprobes got %0d want %0d", obs_probes.size(), exp_p.size());
    else pass_cnt++;
    for (int i = 0; i < exp_p.size(); i++) begin
      a = (i < obs_probes.size()) ? obs_probes[i] : 8'hxx;
      total_cnt++;
      if (a !== exp_p[i]) $display("FAIL k200_probe%0d got %0d want %0d", i, a, exp_p[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_done_cyc != 9) $display("FAIL k200_done_cycle got %0d want 9", obs_done_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b1, 1'b0, 8'd200})
      $display("FAIL k200_outcome got f=%0b e=%0b r=%0d want f=1 e=0 r=200", obs_found, obs_error, obs_result);
    else pass_cnt++;
    total_cnt++;
    if (obs_done_after !== 1'b0 || obs_result_after !== 8'd200)
      $display("FAIL k200_after_done got done=%0b r=%0d want done=0 r=200", obs_done_after, obs_result_after);
    else pass_cnt++;
  endtask

  task automatic test_key_zero();
    logic [7:0] exp_p [$];
    logic [7:0] a;
    exp_p = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    run_search(8'd0, 8'd255, 8'd0, 1'b0);
    total_cnt++;
    if (obs_probes.size() != exp_p.size()) $display("FAIL k0_nprobes got %0d want %0d", obs_probes.size(), exp_p.size());
    else pass_cnt++;
    for (int i = 0; i < exp_p.size(); i++) begin
      a = (i < obs_probes.size()) ? obs_probes[i] : 8'hxx;
      total_cnt++;
      if (a !== exp_p[i]) $display("FAIL k0_probe%0d got %0d want %0d", i, a, exp_p[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b1, 1'b0, 8'd0} || obs_done_cyc != 9)
      $display("FAIL k0_outcome got f=%0b e=%0b r=%0d cyc=%0d want f=1 e=0 r=0 cyc=9",
               obs_found, obs_error, obs_result, obs_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_key_max();
    logic [7:0] exp_p [$];
    logic [7:0] a;
    exp_p = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    run_search(8'd0, 8'd255, 8'd255, 1'b0);
    total_cnt++;
    if (obs_probes.size() != exp_p.size()) $display("FAIL k255_nprobes got %0d want %0d", obs_probes.size(), exp_p.size());
    else pass_cnt++;
    for (int i = 0; i < exp_p.size(); i++) begin
      a = (i < obs_probes.size()) ? obs_probes[i] : 8'hxx;
      total_cnt++;
      if (a !== exp_p[i]) $display("FAIL k255_probe%0d got %0d want %0d", i, a, exp_p[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_done_cyc != 10) $display("FAIL k255_done_cycle got %0d want 10", obs_done_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b1, 1'b0, 8'd255})
      $display("FAIL k255_outcome got f=%0b e=%0b r=%0d want f=1 e=0 r=255", obs_found, obs_error, obs_result);
    else pass_cnt++;
  endtask

  task automatic test_below_range();
    logic [7:0] exp_p [$];
    logic [7:0] a;
    exp_p = '{8'd15, 8'd12, 8'd10};
    run_search(8'd10, 8'd20, 8'd5, 1'b0);
    total_cnt++;
    if (obs_probes.size() != exp_p.size()) $display("FAIL below_nprobes got %0d want %0d", obs_probes.size(), exp_p.size());
    else pass_cnt++;
    for (int i = 0; i < exp_p.size(); i++) begin
      a = (i < obs_probes.size()) ? obs_probes[i] : 8'hxx;
      total_cnt++;
      if (a !== exp_p[i]) $display("FAIL below_probe%0d got %0d want %0d", i, a, exp_p[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b0, 1'b0, 8'd10} || obs_done_cyc != 4)
      $display("FAIL below_outcome got f=%0b e=%0b r=%0d cyc=%0d want f=0 e=0 r=10 cyc=4",
               obs_found, obs_error, obs_result, obs_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_above_range();
    logic [7:0] exp_p [$];
    logic [7:0] a;
    exp_p = '{8'd15, 8'd18, 8'd19, 8'd20};
    run_search(8'd10, 8'd20, 8'd30, 1'b0);
    total_cnt++;
    if (obs_probes.size() != exp_p.size()) $display("FAIL above_nprobes got %0d want %0d", obs_probes.size(), exp_p.size());
    else pass_cnt++;
    for (int i = 0; i < exp_p.size(); i++) begin
      a = (i < obs_probes.size()) ? obs_probes[i] : 8'hxx;
      total_cnt++;
      if (a !== exp_p[i]) $display("FAIL above_probe%0d got %0d want %0d", i, a, exp_p[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b0, 1'b0, 8'd20} || obs_done_cyc != 5)
      $display("FAIL above_outcome got f=%0b e=%0b r=%0d cyc=%0d want f=0 e=0 r=20 cyc=5",
               obs_found, obs_error, obs_result, obs_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_single_element();
    run_search(8'd5, 8'd5, 8'd5, 1'b0);
    total_cnt++;
    if (obs_probes.size() != 1 || obs_done_cyc != 2 || {obs_found, obs_error, obs_result} !== {1'b1, 1'b0, 8'd5})
      $display("FAIL single_elem got n=%0d cyc=%0d f=%0b e=%0b r=%0d want n=1 cyc=2 f=1 e=0 r=5",
               obs_probes.size(), obs_done_cyc, obs_found, obs_error, obs_result);
    else pass_cnt++;
  endtask

  task automatic test_empty_range();
    run_search(8'd9, 8'd3, 8'd5, 1'b0);
    total_cnt++;
    if (obs_done_cyc != 1) $display("FAIL empty_done_cycle got %0d want 1", obs_done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (obs_probes.size() != 0) $display("FAIL empty_probe_valid got %0d probes want 0", obs_probes.size());
    else pass_cnt++;
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b0, 1'b0, 8'd9})
      $display("FAIL empty_outcome got f=%0b e=%0b r=%0d want f=0 e=0 r=9", obs_found, obs_error, obs_result);
    else pass_cnt++;
  endtask

  task automatic test_flag_error();
    run_search(8'd0, 8'd255, 8'd100, 1'b1);
    total_cnt++;
    if ({obs_found, obs_error, obs_result} !== {1'b0, 1'b1, 8'd127} || obs_done_cyc != 2)
      $display("FAIL flag_error got f=%0b e=%0b r=%0d cyc=%0d want f=0 e=1 r=127 cyc=2",
               obs_found, obs_error, obs_result, obs_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_search();
    int saw_done;
    key = 8'd200;
    force_bad = 1'b0;
    @(negedge clk);
    start = 1'b1;
    lo_bound = 8'd0;
    hi_bound = 8'd255;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (probe !== 8'd207 || probe_valid !== 1'b1)
      $display("FAIL midrst_4th_probe got probe=%0d pv=%0b want probe=207 pv=1", probe, probe_valid);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({probe, probe_valid, busy, done, found, error, result} !== 21'd0)
      $display("FAIL midrst_values got probe=%0d pv=%0b busy=%0b done=%0b found=%0b err=%0b result=%0d want all 0",
               probe, probe_valid, busy, done, found, error, result);
    else pass_cnt++;
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    total_cnt++;
    if (saw_done != 0) $display("FAIL midrst_no_done got %0d done/busy cycles want 0", saw_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_p [$];
    logic [7:0] got [$];
    logic [7:0] a;
    int         cyc;
    exp_p = '{8'd127, 8'd63, 8'd95, 8'd79, 8'd71, 8'd75, 8'd77};
    key = 8'd77;
    force_bad = 1'b0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    lo_bound = 8'd0;
    hi_bound = 8'd255;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (probe_valid) got.push_back(probe);
      // Spurious requests while busy, carrying an empty range that would be obvious if taken.
      if (c >= 2 && c <= 4) begin
        start = 1'b1;
        lo_bound = 8'd9;
        hi_bound = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        cyc = c;
        total_cnt++;
        if ({found, error, result} !== {1'b1, 1'b0, 8'd77})
          $display("FAIL b2b_outcome got f=%0b e=%0b r=%0d want f=1 e=0 r=77", found, error, result);
        else pass_cnt++;
        // Request during the DONE cycle must be dropped.
        start = 1'b1;
        lo_bound = 8'd0;
        hi_bound = 8'd255;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd77)
      $display("FAIL b2b_start_in_done got busy=%0b done=%0b r=%0d want busy=0 done=0 r=77", busy, done, result);
    else pass_cnt++;
    total_cnt++;
    if (cyc != 8) $display("FAIL b2b_done_cycle got %0d want 8", cyc);
    else pass_cnt++;
    total_cnt++;
    if (got.size() != exp_p.size()) $display("FAIL b2b_nprobes got %0d want %0d", got.size(), exp_p.size());
    else pass_cnt++;
    for (int i = 0; i < exp_p.size(); i++) begin
      a = (i < got.size()) ? got[i] : 8'hxx;
      total_cnt++;
      if (a !== exp_p[i]) $display("FAIL b2b_probe%0d got %0d want %0d", i, a, exp_p[i]);
      else pass_cnt++;
    end
    // Earliest legal restart is this IDLE cycle.
    run_search(8'd10, 8'd20, 8'd13, 1'b0);
    total_cnt++;
    if ({obs_found, obs_result} !== {1'b1, 8'd13})
      $display("FAIL b2b_restart got f=%0b r=%0d want f=1 r=13", obs_found, obs_result);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_key_200();
    test_key_zero();
    test_key_max();
    test_below_range();
    test_above_range();
    test_single_element();
    test_empty_range();
    test_flag_error();
    test_reset_mid_search();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Sequential binary-search controller that drives the probe operand of an external magnitude comparator and consumes its equal/lower/greater flags. It locates an unknown key inside a programmable range. It is the initiator side of the comparator interface: the comparator answers, this block asks. It sits in the PE next to the comparator instance, serving threshold/index lookups for the control path.

## Interface
- DATA_WIDTH, 8, width of key, bounds, probe and result

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a search; sampled only in IDLE
- lo_bound  in  DATA_WIDTH  inclusive lower search bound, sampled with start
- hi_bound  in  DATA_WIDTH  inclusive upper search bound, sampled with start
- probe  out  DATA_WIDTH  registered value driven to comparator input a (key on input b)
- probe_valid  out  1  high while probe is being evaluated (SEARCH state)
- cmp_equal  in  1  comparator flag, probe == key
- cmp_lower  in  1  comparator flag, probe < key
- cmp_greater  in  1  comparator flag, probe > key
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- found  out  1  valid with done; key located
- error  out  1  valid with done; flags not one-hot
- result  out  DATA_WIDTH  valid with done; located key, else last probe

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE: on start with lo_bound <= hi_bound, load lo=lo_bound, hi=hi_bound, probe=(lo_bound+hi_bound)>>1, go to SEARCH. If lo_bound > hi_bound, go to DONE with found=0, error=0, result=lo_bound, and issue no probe.
- SEARCH: flags are evaluated combinationally against the registered probe in the same cycle. Exactly one of the following applies:
  - equal: go to DONE, found=1, result=probe.
  - lower and probe==hi: DONE, found=0 (key above range).
  - lower: lo=probe+1, probe=(probe+1+hi)>>1.
  - greater and probe==lo: DONE, found=0 (key below range).
  - greater: hi=probe-1, probe=(lo+probe-1)>>1.
  - flags zero or more than one set: DONE, found=0, error=1, result=probe.
- Midpoint sum is computed at DATA_WIDTH+1 bits, then shifted right by 1. The endpoint checks above guarantee lo/hi never wrap, so DATA_WIDTH-bit lo/hi registers suffice.
- DONE: done=1 for exactly one cycle, then go to IDLE. found/error/result hold until the next start is accepted.
- start while busy is ignored; no queuing.

## Timing
- Reset values: probe=0, probe_valid=0, busy=0, done=0, found=0, error=0, result=0, state=IDLE.
- Start accepted at edge t:
  - first probe is valid in cycle t+1;
  - the n-th probe is in cycle t+n;
  - done is asserted in cycle t+N+1, where N is the number of probes.
- Worst case N = DATA_WIDTH+1 probes for a full 2^DATA_WIDTH range.
- Empty range: done in cycle t+1, probe_valid never asserted.
- Reset asserted mid-search: immediate return to IDLE with all reset values; no done pulse.
- start asserted in the DONE cycle is ignored. The earliest re-start is the following (IDLE) cycle.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2);
  - a midpoint function (DATA_WIDTH+1-bit sum, shift).
- No sub-module inside the block. The bench instantiates the existing comparator with a=probe, b=key to close the loop.
- Estimated 150–200 lines RTL.

## Test plan
- Range 0..255, key 200 → probes 127,191,223,207,199,203,201,200; done at t+9, found=1, result=200.
- Range 0..255, key 0 → probes 127,63,31,15,7,3,1,0; found=1, result=0; no hi underflow.
- Range 0..255, key 255 → 9 probes ending 253,254,255; done at t+10, result=255.
- Range 10..20, key 5 → probes 15,12,10; then greater with probe==lo, so found=0, result=10.
- lo_bound=9, hi_bound=3 → done at t+1, found=0, probe_valid never high. Separately, force cmp_lower=cmp_greater=1 on the first probe → error=1, found=0.
- Reset pulse during the 4th probe, then start again (range 0..255, key 77) → outputs return to reset values with no done pulse; the new search completes with found=1, result=77; start pulses while busy have no effect.
